// File: rtl/sal_wr_data_path.sv
// Write-data path: buffers AXI W beats and replays them on DFI a programmable latency after each write grant.
// Optional macro SAL_WR_EARLY_BRESP_EN returns the B response on W acceptance instead of after DFI transmission.
module sal_wr_data_path #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int BURST_LEN  = 2,
    parameter int DEPTH_LG2  = 3,
    parameter int MAX_LAT    = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(MAX_LAT+1)-1:0]  dfi_wren_lat_i,
    input  logic                          wr_gnt_i,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    input  logic [ID_WIDTH-1:0]           wid_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic [DATA_WIDTH/8-1:0]       wstrb_i,
    input  logic                          wlast_i,
    output logic                          bvalid_o,
    input  logic                          bready_i,
    output logic [ID_WIDTH-1:0]           bid_o,
    output logic [1:0]                    bresp_o,
    output logic                          dfi_wrdata_en_o,
    output logic [DATA_WIDTH-1:0]         dfi_wrdata_o,
    output logic [DATA_WIDTH/8-1:0]       dfi_wrdata_mask_o,
    output logic                          err_underflow_o
);

    localparam int MASK_W  = DATA_WIDTH / 8;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int SR_W    = MAX_LAT + BURST_LEN;
    localparam int IDX_W   = $clog2(SR_W);
    localparam int ENTRY_W = DATA_WIDTH + MASK_W + 1;
    localparam int DEPTH   = 1 << DEPTH_LG2;
    localparam int PTR_W   = DEPTH_LG2 + 1;
    localparam logic [SR_W-1:0] GNT_ONES = SR_W'((1 << BURST_LEN) - 1);

    logic [ENTRY_W-1:0]   data_mem_q [DEPTH];
    logic [ID_WIDTH-1:0]  id_mem_q   [DEPTH];

    logic [PTR_W-1:0]     data_wp_q, data_wp_d, data_rp_q, data_rp_d;
    logic [PTR_W-1:0]     id_wp_q, id_wp_d, id_rp_q, id_rp_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic                 err_q, err_d;

    logic                 data_empty, data_full, id_empty, id_full;
    logic                 w_push, id_push, data_pop, b_hs;
    logic [ENTRY_W-1:0]   head;
    logic                 head_last;
    logic [LAT_W-1:0]     lat_eff;
    logic [IDX_W-1:0]     tap_idx;
    logic [SR_W-1:0]      sr_tap;

    always_comb begin
        data_empty = (data_wp_q == data_rp_q);
        data_full  = (data_wp_q[DEPTH_LG2-1:0] == data_rp_q[DEPTH_LG2-1:0]) &&
                     (data_wp_q[DEPTH_LG2] != data_rp_q[DEPTH_LG2]);
        id_empty   = (id_wp_q == id_rp_q);
        id_full    = (id_wp_q[DEPTH_LG2-1:0] == id_rp_q[DEPTH_LG2-1:0]) &&
                     (id_wp_q[DEPTH_LG2] != id_rp_q[DEPTH_LG2]);

        // The window of ones sits at bits 0..BURST_LEN-1 one cycle after the grant,
        // so tapping its top bit at L+BURST_LEN-2 makes the first beat land L cycles after the grant.
        lat_eff = (dfi_wren_lat_i == '0) ? LAT_W'(1) : dfi_wren_lat_i;
        tap_idx = IDX_W'(int'(lat_eff) + BURST_LEN - 2);
        sr_tap  = sr_q >> tap_idx;

        dfi_wrdata_en_o   = sr_tap[0];
        head              = data_mem_q[data_rp_q[DEPTH_LG2-1:0]];
        dfi_wrdata_o      = head[ENTRY_W-1 -: DATA_WIDTH];
        dfi_wrdata_mask_o = head[MASK_W:1];
        head_last         = head[0];

        wready_o        = ~data_full & ~id_full;
        bid_o           = id_mem_q[id_rp_q[DEPTH_LG2-1:0]];
        bresp_o         = 2'b00;
        err_underflow_o = err_q;

        w_push   = wvalid_i & wready_o;
        id_push  = w_push & wlast_i;
        data_pop = dfi_wrdata_en_o & ~data_empty;
    end

`ifdef SAL_WR_EARLY_BRESP_EN
    logic unused_head_last;
    assign unused_head_last = head_last;

    always_comb begin
        bvalid_o = ~id_empty;
        b_hs     = bvalid_o & bready_i;
    end
`else
    logic [PTR_W-1:0] cnt_q, cnt_d;

    // Responses become visible only once the last beat of a burst has left on DFI.
    always_comb begin
        bvalid_o = (cnt_q != '0) & ~id_empty;
        b_hs     = bvalid_o & bready_i;
        cnt_d    = cnt_q;
        case ({data_pop & head_last, b_hs})
            2'b10:   cnt_d = cnt_q + PTR_W'(1);
            2'b01:   cnt_d = cnt_q - PTR_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        data_wp_d = data_wp_q + PTR_W'(w_push);
        data_rp_d = data_rp_q + PTR_W'(data_pop);
        id_wp_d   = id_wp_q + PTR_W'(id_push);
        id_rp_d   = id_rp_q + PTR_W'(b_hs);
        sr_d      = {sr_q[SR_W-2:0], 1'b0} | (wr_gnt_i ? GNT_ONES : '0);
        err_d     = err_q | (dfi_wrdata_en_o & data_empty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_wp_q <= '0;
            data_rp_q <= '0;
            id_wp_q   <= '0;
            id_rp_q   <= '0;
            sr_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            data_wp_q <= data_wp_d;
            data_rp_q <= data_rp_d;
            id_wp_q   <= id_wp_d;
            id_rp_q   <= id_rp_d;
            sr_q      <= sr_d;
            err_q     <= err_d;
        end
    end

    // Storage arrays need no reset: pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push)  data_mem_q[data_wp_q[DEPTH_LG2-1:0]] <= {wdata_i, ~wstrb_i, wlast_i};
        if (id_push) id_mem_q[id_wp_q[DEPTH_LG2-1:0]]     <= wid_i;
    end

endmodule

// File: tb/tb_sal_wr_data_path.sv
// Scoreboard bench for sal_wr_data_path: W beats queue expected DFI beats and B IDs, monitors pop and compare.
// Honours SAL_WR_EARLY_BRESP_EN for the response-timing scenario.
module tb_sal_wr_data_path;

    localparam int DW = 128;
    localparam int IW = 4;
    localparam int MW = 16;
    localparam int BL = 2;
    localparam int LW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [MW-1:0] m;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic [LW-1:0] lat;
    logic          wrGnt, wValid, wReady, wLast, bValid, bReady, dfiEn, errUnderflow;
    logic [IW-1:0] wId, bId;
    logic [DW-1:0] wData, dfiData;
    logic [MW-1:0] wStrb, dfiMask;
    logic [1:0]    bResp;

    beat_t         dataQ[$];
    logic [IW-1:0] idQ[$];
    beat_t         expBeat;
    int            checks = 0;
    int            errors = 0;
    bit            allowUnderflow = 1'b0;

    sal_wr_data_path dut (
        .clk(clk), .rst_n(rstN), .dfi_wren_lat_i(lat), .wr_gnt_i(wrGnt),
        .wvalid_i(wValid), .wready_o(wReady), .wid_i(wId), .wdata_i(wData),
        .wstrb_i(wStrb), .wlast_i(wLast), .bvalid_o(bValid), .bready_i(bReady),
        .bid_o(bId), .bresp_o(bResp), .dfi_wrdata_en_o(dfiEn), .dfi_wrdata_o(dfiData),
        .dfi_wrdata_mask_o(dfiMask), .err_underflow_o(errUnderflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitors compare DFI beats and B responses against the scoreboard queues.
    always @(negedge clk) begin
        if (rstN === 1'b1 && dfiEn === 1'b1) begin
            if (dataQ.size() > 0) begin
                expBeat = dataQ.pop_front();
                checkOutput("dfi_wrdata", dfiData, expBeat.d);
                checkOutput("dfi_mask", DW'(dfiMask), DW'(expBeat.m));
            end else begin
                checkOutput("en_without_data", DW'(dfiEn), DW'(allowUnderflow));
            end
        end
        if (rstN === 1'b1 && bValid === 1'b1 && bReady === 1'b1) begin
            checkOutput("bresp", DW'(bResp), DW'(0));
            if (idQ.size() > 0) checkOutput("bid_order", DW'(bId), DW'(idQ.pop_front()));
            else                checkOutput("unexpected_bvalid", DW'(bValid), DW'(0));
        end
    end

    // Drives one W beat (entered at posedge+1) and records its expectations on acceptance.
    task automatic applyStimulus(input logic [IW-1:0] id, input logic [DW-1:0] d,
                                 input logic [MW-1:0] s, input logic last);
        int waitCycles = 0;
        wValid = 1'b1; wId = id; wData = d; wStrb = s; wLast = last;
        @(negedge clk);
        while (wReady !== 1'b1 && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("wready_accept", DW'(wReady), DW'(1));
        @(posedge clk);
        if (wReady === 1'b1) begin
            dataQ.push_back('{d: d, m: ~s});
            if (last) idQ.push_back(id);
        end
        #1 wValid = 1'b0; wLast = 1'b0;
    endtask

    task automatic grantAndCheck(input int l, input bit checkB, input bit checkErr);
        int effL = (l == 0) ? 1 : l;
        lat = LW'(l);
        wrGnt = 1'b1;
        @(negedge clk);
        checkOutput("en_grant_cycle", DW'(dfiEn), DW'(0));
        @(posedge clk);
        #1 wrGnt = 1'b0;
        for (int k = 1; k <= effL + BL; k++) begin
            @(negedge clk);
            checkOutput("en_window", DW'(dfiEn), DW'(k >= effL && k <= effL + BL - 1));
            if (checkB)   checkOutput("bvalid_deferred", DW'(bValid), DW'(k == effL + BL));
            if (checkErr) checkOutput("err_sticky", DW'(errUnderflow), DW'(k > effL));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randData(output logic [DW-1:0] d);
        d = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        rstN = 1'b0; lat = LW'(3); wrGnt = 1'b0; wValid = 1'b0; wId = '0;
        wData = '0; wStrb = '0; wLast = 1'b0; bReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_bvalid", DW'(bValid), DW'(0));
        checkOutput("rst_en", DW'(dfiEn), DW'(0));
        checkOutput("rst_err", DW'(errUnderflow), DW'(0));
        @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst_wready", DW'(wReady), DW'(1));
        @(posedge clk);
        #1;

        $display("[TB] basic burst, latency 3");
        applyStimulus(4'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h00FF, 1'b0);
        randData(d);
        applyStimulus(4'd3, d, 16'hF0F0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        grantAndCheck(3, 1'b0, 1'b0);

        $display("[TB] deferred response");
        bReady = 1'b0;
        randData(d);
        applyStimulus(4'd5, d, 16'hFFFF, 1'b0);
        randData(d);
        applyStimulus(4'd5, d, 16'h1234, 1'b1);
`ifdef SAL_WR_EARLY_BRESP_EN
        @(negedge clk);
        checkOutput("bvalid_early", DW'(bValid), DW'(1));
        checkOutput("bid_early", DW'(bId), DW'(5));
        @(posedge clk);
        #1 bReady = 1'b1;
        @(posedge clk);
        #1 bReady = 1'b0;
        grantAndCheck(3, 1'b0, 1'b0);
`else
        repeat (20) begin
            @(negedge clk);
            checkOutput("bvalid_before_dfi", DW'(bValid), DW'(0));
        end
        @(posedge clk);
        #1;
        grantAndCheck(3, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bvalid_after_dfi", DW'(bValid), DW'(1));
        checkOutput("bid_after_dfi", DW'(bId), DW'(5));
        @(posedge clk);
        #1 bReady = 1'b1;
        @(posedge clk);
        #1 bReady = 1'b0;
`endif
        @(negedge clk);
        checkOutput("bvalid_consumed", DW'(bValid), DW'(0));
        @(posedge clk);
        #1;

        $display("[TB] fill, drain and held responses");
        for (int i = 0; i < 8; i++) begin
            randData(d);
            applyStimulus(IW'(i / 2 + 8), d, 16'($urandom), (i % 2) == 1);
        end
        @(negedge clk);
        checkOutput("wready_full", DW'(wReady), DW'(0));
        @(posedge clk);
        #1;
        grantAndCheck(3, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("wready_after_pop", DW'(wReady), DW'(1));
        @(posedge clk);
        #1;
        repeat (3) grantAndCheck(4, 1'b0, 1'b0);
        repeat (10) begin
            @(negedge clk);
            checkOutput("bvalid_held", DW'(bValid), DW'(1));
            checkOutput("bid_stable", DW'(bId), DW'(idQ[0]));
        end
        @(posedge clk);
        #1 bReady = 1'b1;
        for (int c = 0; c < 20 && idQ.size() > 0; c++) @(posedge clk);
        #1 bReady = 1'b0;
        checkOutput("b_remaining", DW'(idQ.size()), DW'(0));
        @(negedge clk);
        checkOutput("bvalid_drained", DW'(bValid), DW'(0));
        @(posedge clk);
        #1;

        $display("[TB] latency 0 behaves as 1");
        bReady = 1'b1;
        randData(d);
        applyStimulus(4'd9, d, 16'hA5A5, 1'b0);
        randData(d);
        applyStimulus(4'd9, d, 16'h0001, 1'b1);
        grantAndCheck(0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] underflow and reset clear");
        allowUnderflow = 1'b1;
        @(negedge clk);
        checkOutput("err_before", DW'(errUnderflow), DW'(0));
        @(posedge clk);
        #1;
        grantAndCheck(3, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("err_held", DW'(errUnderflow), DW'(1));
        @(posedge clk);
        #1 rstN = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
        allowUnderflow = 1'b0;
        @(negedge clk);
        checkOutput("err_cleared", DW'(errUnderflow), DW'(0));
        checkOutput("wready_after_rst", DW'(wReady), DW'(1));
        @(posedge clk);
        #1;

        $display("[TB] reset during pending burst");
        bReady = 1'b0;
        randData(d);
        applyStimulus(4'd6, d, 16'hFFFF, 1'b0);
        randData(d);
        applyStimulus(4'd6, d, 16'hFFFF, 1'b1);
        lat = LW'(5);
        wrGnt = 1'b1;
        @(posedge clk);
        #1 wrGnt = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
        dataQ.delete();
        idQ.delete();
        repeat (10) begin
            @(negedge clk);
            checkOutput("en_discarded", DW'(dfiEn), DW'(0));
            checkOutput("bvalid_discarded", DW'(bValid), DW'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
